fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning PC/instruction-address width in bits.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, meaning instruction word width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two >= 2.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port imem_addr, output, ADDR_WIDTH, the current fetch address driven to the combinational instruction memory.
REQ-008 SHALL have port imem_rdata, input, INSTR_WIDTH, the instruction at imem_addr, valid in the same cycle.
REQ-009 SHALL have port redirect_valid, input, 1, a branch/jump redirect request from decode/execute.
REQ-010 SHALL have port redirect_pc, input, ADDR_WIDTH, the redirect target.
REQ-011 SHALL have port out_valid, output, 1, meaning the head entry is valid.
REQ-012 SHALL have port out_instr, output, INSTR_WIDTH, the head-entry instruction.
REQ-013 SHALL have port out_pc, output, ADDR_WIDTH, the head-entry PC.
REQ-014 SHALL have port out_ready, input, 1, decode accepts the head; driven as ~hazard.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1, the current number of valid entries.

Function
REQ-016 SHALL hold fetch_pc in a register; imem_addr SHALL equal fetch_pc combinationally.
REQ-017 Push: in a non-redirect cycle with (count < DEPTH or pop), the block SHALL write {fetch_pc, imem_rdata} at the tail and advance fetch_pc by 4, modulo 2^ADDR_WIDTH.
REQ-018 Pop: in a non-redirect cycle with out_valid and out_ready, the block SHALL remove the head.
REQ-019 SHALL keep fetch_pc unchanged when full with no pop, and perform no memory write.
REQ-020 Push and pop in the same cycle SHALL be legal at any occupancy, including full, and SHALL leave count unchanged.
REQ-021 out_valid SHALL equal (count != 0); out_instr/out_pc SHALL come from the registered head entry, with no combinational path from imem_rdata.
REQ-022 Redirect has highest priority: the cycle after redirect_valid=1, count SHALL be 0, both pointers SHALL be reset, and fetch_pc SHALL be {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
REQ-023 In a redirect cycle, push and pop SHALL both be suppressed, and the current out_valid/out_ready handshake SHALL be discarded.
REQ-024 Latency: a word pushed into an empty queue SHALL appear on out_* with out_valid=1 on the next cycle, giving 1 cycle from fetch to decode.
REQ-025 Head/tail pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow below 0.
REQ-026 With out_ready held at 1 and no redirect, the block SHALL sustain one instruction per cycle.
REQ-027 Entries not at the head SHALL NOT be observable at the outputs.

Reset
REQ-028 While reset=0, the block SHALL force fetch_pc=RESET_PC, head=tail=0, count=0, out_valid=0, and imem_addr=RESET_PC, immediately and without waiting for clk.
REQ-029 Reset asserted mid-operation SHALL discard all entries and any pending redirect.
REQ-030 out_instr/out_pc SHALL reset to 0.
REQ-031 The first push SHALL occur on the first rising clk edge with reset=1, at address RESET_PC.

Verification
REQ-032 Reset release, out_ready=1, memory word at A = A: out_pc/out_instr SHALL read 0,4,8,... on consecutive cycles starting 1 cycle after the first edge, with count <= 1.
REQ-033 out_ready=0 for 10 cycles with DEPTH=4: count SHALL saturate at 4, imem_addr SHALL hold at 0x10, and out_pc SHALL hold at 0x0.
REQ-034 Full queue with out_ready=1 for one cycle: the entry at 0x10 SHALL be pushed in the same cycle, count SHALL stay 4, and the next head SHALL be 0x4.
REQ-035 redirect_valid=1, redirect_pc=0x103 with queue at 3 entries: the next cycle SHALL show count=0, out_valid=0, imem_addr=0x100; the cycle after SHALL show out_pc=0x100.
REQ-036 fetch_pc=0xFFFFFFFC, out_ready=1: the next fetch SHALL be 0x0 with no X values.
REQ-037 reset pulsed low asynchronously between edges while 2 entries are queued: outputs SHALL clear immediately, and refill SHALL resume from RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch into a small FIFO that feeds decode, flushed by redirects
module fetch_queue #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDR_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0]   imem_rdata,
    input  logic                     redirect_valid,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc,
    output logic                     out_valid,
    output logic [INSTR_WIDTH-1:0]   out_instr,
    output logic [ADDR_WIDTH-1:0]    out_pc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic                   push;
    logic                   pop;
    logic                   unused_bits;

    // Redirect targets are word aligned, so the low address bits are dropped.
    assign unused_bits = ^redirect_pc[1:0];

    assign imem_addr = fetch_pc;
    assign out_valid = count != '0;
    // Head comes straight from registered storage; imem_rdata never reaches the outputs.
    assign out_pc    = pc_mem[head];
    assign out_instr = instr_mem[head];

    // Handshake qualification: a redirect suppresses both push and pop; a pop frees a slot for a push when full.
    always_comb begin
        pop  = !redirect_valid && out_valid && out_ready;
        push = !redirect_valid && ((count < CW'(DEPTH)) || pop);
    end

    // Control state: fetch address, pointers and occupancy, with redirect flushing everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                tail     <= tail + 1'b1;
            end
            if (pop)
                head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage: cleared on reset so the head reads zero, written at the tail on every push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[tail]    <= fetch_pc;
            instr_mem[tail] <= imem_rdata;
        end
    end
endmodule
